// File: rtl/input_debouncer_pkg.sv
// Shared types and default sizing for the input debouncer slice.
// The state encoding is also used by other input-conditioning blocks.
package input_debouncer_pkg;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

endpackage

// File: rtl/input_debouncer_if.sv
// Pin-side raw input and the conditioned outputs of one debouncer instance.
// The master drives raw_in; the slave (the debouncer) drives the rest.
interface input_debouncer_if;

    logic raw_in;
    logic a;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output raw_in,
        input  a,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  raw_in,
        output a,
        output rise,
        output fall,
        output busy
    );

endinterface

// File: rtl/input_debouncer_sync_chain.sv
// Generic N-flop synchroniser for an asynchronous single-bit input.
// q is the last flop of the chain; all flops clear on reset.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces one raw board input into a clean level 'a' plus rise/fall strobes.
// A new level is accepted only after DEBOUNCE_CYCLES equal synchronised samples.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input logic             clk,
    input logic             reset,
    input_debouncer_if.slave bus
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.raw_in),
        .q     (s)
    );

    // Qualification FSM: a reversal of s during WAIT_* abandons the candidate level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    a_d     = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    a_d     = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                a_d     = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (2 sync stages, 4-sample debounce) against a
// run-length reference model of the debounce rule.
module tb_input_debouncer;

    localparam int unsigned SYNC = 2;
    localparam int unsigned N    = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    input_debouncer_if bus ();

    input_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw delayed by SYNC edges, then count consecutive samples differing from 'a'.
    logic sq[$];
    logic a_m, rise_m, fall_m, busy_m;
    int   run_m;

    task automatic model_reset();
        sq.delete();
        for (int i = 0; i < int'(SYNC); i++) sq.push_back(1'b0);
        a_m = 1'b0; rise_m = 1'b0; fall_m = 1'b0; busy_m = 1'b0; run_m = 0;
    endtask

    task automatic model_edge(input logic r);
        logic s;
        if (reset) begin
            model_reset();
        end else begin
            s = sq.pop_front();
            sq.push_back(r);
            rise_m = 1'b0;
            fall_m = 1'b0;
            if (s != a_m) begin
                run_m++;
                if (run_m == int'(N)) begin
                    a_m = ~a_m;
                    if (a_m) rise_m = 1'b1; else fall_m = 1'b1;
                    run_m = 0;
                end
            end else begin
                run_m = 0;
            end
            busy_m = (run_m != 0);
        end
    endtask

    task automatic step(input logic r);
        bus.raw_in = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    function automatic logic [3:0] dut_out();
        return {bus.a, bus.rise, bus.fall, bus.busy};
    endfunction

    function automatic logic [3:0] mdl_out();
        return {a_m, rise_m, fall_m, busy_m};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            total++;
            if (dut_out() !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d: a/rise/fall/busy got %b exp 0000", k, dut_out());
            end
        end
        bus.raw_in = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0);
            total++;
            if (dut_out() !== mdl_out()) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d: got %b exp %b", k, dut_out(), mdl_out());
            end
        end
    endtask

    task automatic test_glitch();
        logic seen_busy, seen_rise;
        seen_busy = 1'b0;
        seen_rise = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(k < 3);
            seen_busy |= bus.busy;
            seen_rise |= bus.rise;
            total++;
            if (dut_out() !== mdl_out() || bus.a !== 1'b0) begin
                bad++;
                $display("FAIL glitch cyc=%0d: got %b exp %b", k, dut_out(), mdl_out());
            end
        end
        total++;
        if ({seen_busy, seen_rise, bus.busy} !== 3'b100) begin
            bad++;
            $display("FAIL glitch_summary: busy_seen/rise_seen/busy_end got %b exp 100",
                     {seen_busy, seen_rise, bus.busy});
        end
    endtask

    task automatic test_clean_edge(input logic lvl);
        logic [3:0] exp_v;
        for (int k = 1; k <= 8; k++) begin
            step(lvl);
            exp_v = {(k >= 6) ? lvl : ~lvl, lvl && k == 6, !lvl && k == 6, k >= 3 && k <= 5};
            total++;
            if (dut_out() !== exp_v || dut_out() !== mdl_out()) begin
                bad++;
                $display("FAIL clean_%s edge=%0d: got %b exp %b model %b",
                         lvl ? "rise" : "fall", k, dut_out(), exp_v, mdl_out());
            end
        end
    endtask

    task automatic test_bounce();
        int rises;
        logic r;
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            r = (i < 10) ? ((i / 2) % 2 == 0) : 1'b1;
            step(r);
            if (bus.rise) rises++;
            total++;
            if (bus.a !== (i >= 13) || dut_out() !== mdl_out()) begin
                bad++;
                $display("FAIL bounce edge=%0d: got %b exp a=%0d model %b",
                         i + 1, dut_out(), i >= 13, mdl_out());
            end
        end
        total++;
        if (rises != 1) begin
            bad++;
            $display("FAIL bounce_rise_count: got %0d exp 1", rises);
        end
    endtask

    task automatic test_boundary();
        int falls;
        logic pat_rej[$];
        logic pat_acc[$];
        pat_rej = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        pat_acc = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        falls = 0;
        foreach (pat_rej[i]) begin
            step(pat_rej[i]);
            if (bus.fall) falls++;
            total++;
            if (dut_out() !== mdl_out() || bus.a !== 1'b1) begin
                bad++;
                $display("FAIL boundary_reject idx=%0d: got %b model %b", i, dut_out(), mdl_out());
            end
        end
        foreach (pat_acc[i]) begin
            step(pat_acc[i]);
            if (bus.fall) falls++;
            total++;
            if (dut_out() !== mdl_out()) begin
                bad++;
                $display("FAIL boundary_accept idx=%0d: got %b model %b", i, dut_out(), mdl_out());
            end
        end
        total++;
        if (falls != 1 || bus.a !== 1'b0) begin
            bad++;
            $display("FAIL boundary_summary: falls=%0d a=%b exp falls=1 a=0", falls, bus.a);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) step(1'b1);
        total++;
        if (bus.busy !== 1'b1 || bus.a !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_pre: busy=%b a=%b exp busy=1 a=0", bus.busy, bus.a);
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        total++;
        if (dut_out() !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid_async: got %b exp 0000", dut_out());
        end
        step(1'b1);
        step(1'b1);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1);
            total++;
            if (bus.a !== (k >= 6) || bus.rise !== (k == 6) || dut_out() !== mdl_out()) begin
                bad++;
                $display("FAIL reset_mid_requal edge=%0d: got %b model %b", k, dut_out(), mdl_out());
            end
        end
    endtask

    task automatic test_random();
        logic r;
        int   hold;
        r = 1'b0;
        hold = 0;
        for (int k = 0; k < 400; k++) begin
            if (hold == 0) begin
                r = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 6));
            end
            hold--;
            step(r);
            total++;
            if (dut_out() !== mdl_out() || (bus.rise && bus.fall)) begin
                bad++;
                $display("FAIL random cyc=%0d: got %b exp %b", k, dut_out(), mdl_out());
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.raw_in = 1'b0;
        model_reset();
        test_reset();
        test_glitch();
        test_clean_edge(1'b1);
        test_clean_edge(1'b0);
        test_bounce();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
